// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_e        : FSM encoding (IDLE waits for start, SHIFT runs iterations)
//   ADD3_THRESHOLD : digit value at or above which the add-3 correction applies
//   cnt_width()    : width of the bit counter, able to hold IN_WIDTH itself
//   pow10()        : used to check at elaboration that DIGITS is large enough
package bin_to_bcd_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

  function automatic int cnt_width(input int in_width);
    return $clog2(in_width + 1);
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Combinational add-3 correction for one BCD digit of the double-dabble
// scratch register.
//   digit_in  : current 4-bit scratch digit (0..9)
//   digit_out : digit_in + 3 when digit_in >= 5, else digit_in
// The corrected value is at most 12, so it never carries out of the digit.
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    digit_out = (digit_in >= ADD3_THRESHOLD) ? digit_in + 4'd3 : digit_in;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : conversion request, sampled only in IDLE
//   bin_in  : unsigned binary value, captured on the accepting edge
//   busy    : high while a conversion is running
//   done    : one-cycle pulse, bcd_out updated on the same edge
//   bcd_out : packed BCD result, digit k in bits [4k+3:4k] (k=0 is units)
// bcd_out is a separate holding register so downstream seven-segment
// decoders only ever see finished results.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CNT_W = cnt_width(IN_WIDTH);
  localparam int BCD_W = 4 * DIGITS;
  localparam longint unsigned MAX_IN = (64'd1 << IN_WIDTH) - 64'd1;

  // Too few digits would silently truncate the largest inputs.
  if (pow10(DIGITS) <= MAX_IN) begin : g_digits_too_small
    $fatal(1, "bin_to_bcd_seq: DIGITS too small for IN_WIDTH");
  end

  state_e              state_q,   state_d;
  logic [IN_WIDTH-1:0] bin_q,     bin_d;
  logic [BCD_W-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic [BCD_W-1:0]    bcd_q,     bcd_d;

  // Add-3 corrected view of the scratch register, ahead of this edge's shift.
  logic [BCD_W-1:0]    adj;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch_q[4*k +: 4]),
      .digit_out (adj[4*k +: 4])
    );
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d     = bin_in;
          scratch_d = '0;
          cnt_d     = CNT_W'(IN_WIDTH);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        {scratch_d, bin_d} = {adj, bin_q} << 1;
        cnt_d              = cnt_q - 1'b1;
        // Last iteration: publish the result and hand back to IDLE.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = scratch_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (IN_WIDTH=8, DIGITS=3).
// Expected results are queued when a conversion is requested and compared
// by a monitor whenever done is seen.
module tb_bin_to_bcd_seq;

  localparam int IN_WIDTH = 8;
  localparam int DIGITS   = 3;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [IN_WIDTH-1:0] bin_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;

  int n_checks = 0;
  int n_fail   = 0;
  int done_count = 0;
  logic [11:0] sb[$];

  bin_to_bcd_seq #(.IN_WIDTH(IN_WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference decimal conversion.
  function automatic logic [11:0] to_bcd(input int v);
    return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'b100_0000;
      4'd1: return 7'b111_1001;
      4'd2: return 7'b010_0100;
      4'd3: return 7'b011_0000;
      4'd4: return 7'b001_1001;
      4'd5: return 7'b001_0010;
      4'd6: return 7'b000_0010;
      4'd7: return 7'b111_1000;
      4'd8: return 7'b000_0000;
      4'd9: return 7'b001_0000;
      default: return 7'b111_1111;
    endcase
  endfunction

  // Monitor: compares every done against the scoreboard.
  initial begin
    logic prev_done;
    logic [11:0] exp_v;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        done_count++;
        check("busy_done_excl", busy, 0);
        check("done_width", prev_done, 0);
        for (int k = 0; k < DIGITS; k++)
          check("digit_range", bcd_out[4*k +: 4] > 4'd9, 0);
        if (sb.size() == 0) begin
          check("unexpected_done", done, 0);
        end else begin
          exp_v = sb.pop_front();
          check("bcd_out", bcd_out, exp_v);
        end
      end
      prev_done = done;
    end
  end

  // Drive a one-cycle start; returns just after the accepting edge.
  task automatic start_conv(input int v);
    @(posedge clk);
    #1;
    start  = 1'b1;
    bin_in = IN_WIDTH'(v);
    sb.push_back(to_bcd(v));
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = IN_WIDTH'($urandom);
  endtask

  // Wait (bounded) for done at negedges; optionally check bcd_out is held.
  task automatic wait_done(output int n_edges, output int busy_cycles,
                           input bit hold_en, input logic [11:0] hold_val);
    bit seen;
    seen = 1'b0;
    n_edges = 0;
    busy_cycles = 0;
    while (!seen && n_edges < 40) begin
      @(negedge clk);
      n_edges++;
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cycles++;
        if (hold_en) check("bcd_hold", bcd_out, hold_val);
        bin_in = IN_WIDTH'($urandom);
      end
    end
    if (!seen) check("timeout_done", done, 1);
  endtask

  initial begin
    int n, bc, dc;
    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bcd", bcd_out, 0);
    rst_n = 1'b1;

    // 0: latency and busy duration
    start_conv(0);
    wait_done(n, bc, 1'b0, 12'h000);
    check("latency_0", n - 1, 8);
    check("busy_cycles_0", bc, 8);

    // 255 and the units digit through a seven-segment decoder
    start_conv(255);
    wait_done(n, bc, 1'b0, 12'h000);
    check("latency_255", n - 1, 8);
    check("seg7_units", seg7(bcd_out[3:0]), 7'b001_0010);
    @(negedge clk);
    check("done_clears", done, 0);

    // Back-to-back: start held in the done cycle
    start_conv(99);
    wait_done(n, bc, 1'b0, 12'h000);
    start  = 1'b1;
    bin_in = 8'd100;
    sb.push_back(to_bcd(100));
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, bc, 1'b1, 12'h099);
    check("latency_b2b", n - 1, 8);

    // Start while busy is ignored
    start_conv(42);
    @(posedge clk);
    @(posedge clk);
    #1;
    start  = 1'b1;
    bin_in = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, bc, 1'b0, 12'h000);
    dc = done_count;
    repeat (20) @(negedge clk);
    check("no_extra_done", done_count, dc);
    check("bcd_42_held", bcd_out, 12'h042);

    // Reset mid-conversion
    start_conv(200);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bcd", bcd_out, 0);
    void'(sb.pop_back());
    dc = done_count;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_done_after_abort", done_count, dc);
    check("idle_after_abort", busy, 0);

    // Exhaustive back-to-back sweep
    start_conv(0);
    for (int v = 0; v < 256; v++) begin
      wait_done(n, bc, 1'b0, 12'h000);
      if (v < 255) begin
        start  = 1'b1;
        bin_in = IN_WIDTH'(v + 1);
        sb.push_back(to_bcd(v + 1));
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    repeat (12) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the per-digit BCD-to-seven-segment decoders. Each 4-bit slice of bcd_out drives one decoder instance, so binary counts and ALU results can be shown as decimal on the HEX displays. A start/busy/done handshake lets a controller request a conversion and know when the result is valid.

Parameters:
IN_WIDTH, 8, width of the unsigned binary input
DIGITS, 3, number of BCD digits produced; must satisfy 10^DIGITS > 2^IN_WIDTH - 1 (elaboration-time check; fail if violated)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request; sampled only in IDLE
bin_in  input  IN_WIDTH  unsigned binary value; captured on the accepting edge only
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse; bcd_out updated on the same edge
bcd_out  output  4*DIGITS  packed BCD result; digit k in bits [4k+3:4k], where k=0 is the units digit

Behaviour:
- Interface (already decided): single clock clk; reset rst_n is asynchronous and active-low.
- Reset values while rst_n=0, and immediately on assertion: state=IDLE, busy=0, done=0, bcd_out=0, and all internal shift/scratch registers and the bit counter cleared.
- States:
  - IDLE: wait for start.
  - SHIFT: perform shift iterations.
  - There is no separate DONE state; completion is folded into the final SHIFT edge.
- IDLE, start=1 at edge E0:
  - load bin_in into the binary shift register;
  - clear the BCD scratch register (4*DIGITS bits);
  - set bit counter = IN_WIDTH;
  - set busy=1;
  - state -> SHIFT.
- SHIFT, edges E1..E_IN_WIDTH, one iteration per edge:
  - for each scratch digit, digit >= 5 ? digit + 3 : digit, computed combinationally;
  - then shift {scratch, binreg} left by 1 with 0 fed in at the LSB;
  - decrement the counter.
- Final edge E_IN_WIDTH (counter == 1 before the edge):
  - bcd_out <= adjusted-and-shifted scratch value;
  - done <= 1, busy <= 0, state -> IDLE.
- Latency: result valid, with done high, for the cycle following edge E_IN_WIDTH, i.e. IN_WIDTH clocks after the accepting edge. done clears at the next edge unless a new conversion completes.
- busy is high from E0 up to, but not including, the cycle in which done is high. busy and done are never high together.
- start while busy is ignored. bin_in changes during SHIFT have no effect.
- Back-to-back: start=1 in the cycle where done=1 is accepted (state is IDLE). The new conversion begins while the old bcd_out is still held.
- bcd_out holds its last result through subsequent conversions and changes only on a completion edge. The decoders therefore never see intermediate values.
- Reset mid-conversion: abort immediately, return to IDLE with all outputs zero, and produce no done pulse.
- Arithmetic: all values unsigned. Add-3 is applied per digit on 4 bits and cannot carry out of the digit, because the adjusted input is at most 9 before the shift. Every bcd_out digit is always in 0..9.

Decomposition:
- Shared package: state encoding constants (IDLE, SHIFT), the add-3 threshold constant (5), and the bit-counter width function clog2(IN_WIDTH+1).
- Sub-module bcd_digit_adj (combinational, 4-bit in, 4-bit out, add-3 when >= 5), instantiated DIGITS times via generate. The top module holds the FSM, counter and registers.

Test Plan:
- Reset, then start with bin_in=8'd0 -> done pulse exactly 8 clocks after the accepting edge; bcd_out=12'h000; busy high for 8 cycles before done.
- bin_in=8'd255 -> bcd_out=12'h255, done one cycle wide. Digit 0 (5) fed to a BCD-to-seven-segment decoder shows segment pattern 7'b001_0010.
- bin_in=8'd99, then start held high in the done cycle with bin_in=8'd100 -> first result 12'h099, second done 8 clocks later with 12'h100; bcd_out stays 12'h099 in between.
- Start pulse with 8'd42, then start=1 with bin_in=8'd7 on cycle 3 of busy -> second request ignored; single done with bcd_out=12'h042; no further done.
- Start with 8'd200, assert rst_n=0 on the 4th SHIFT cycle -> busy, done and bcd_out go to 0 asynchronously. After release, no done appears until a new start is issued.
- Exhaustive sweep 0..255 with back-to-back starts -> every result matches a reference decimal conversion; every digit is <= 9.
